hazard3_reset_ctrl: RTL and testbench



---
 rtl/hazard3_reset_ctrl_pkg.sv | 16 +
 rtl/hazard3_reset_ctrl_hart.sv | 95 +++++++++
 rtl/hazard3_reset_ctrl.sv | 41 ++++
 tb/tb_hazard3_reset_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hazard3_reset_ctrl_pkg.sv
// Shared types for the Hazard3 per-hart reset controller: hart FSM encoding
// and the pulse-counter width derivation.
package hazard3_reset_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_SYNC = 2'd2
  } hart_state_e;

  // A MIN_PULSE of 1 still needs a 1-bit counter.
  function automatic int cnt_width(input int min_pulse);
    return (min_pulse > 1) ? $clog2(min_pulse) : 1;
  endfunction

endpackage

// File: rtl/hazard3_reset_ctrl_hart.sv
// One hart's reset sequencer: minimum-width hold, synchronised release and a
// done flag that can only rise once this hart's current reset has released.
module hazard3_reset_ctrl_hart
  import hazard3_reset_ctrl_pkg::*;
#(
  parameter int MIN_PULSE   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int W_CNT       = cnt_width(MIN_PULSE)
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic rst_n,
  output logic done
);

  localparam logic [W_CNT-1:0] CNT_RELOAD = W_CNT'(MIN_PULSE - 1);

  hart_state_e            state_q, state_d;
  logic [W_CNT-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES:0]   chain_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= CNT_RELOAD;
      chain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chain_d     = chain_q;
    done_d      = done_q;
    chain_shift = {chain_q, 1'b1};

    case (state_q)
      ST_RUN: begin
        if (req) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_RELOAD;
          chain_d = '0;
          done_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end

      // A request still high once the count expires stretches the reset.
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!req) begin
          state_d = ST_SYNC;
        end
      end

      // A re-request restarts the whole minimum pulse; done stays low.
      ST_SYNC: begin
        if (req) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_RELOAD;
          chain_d = '0;
          done_d  = 1'b0;
        end else begin
          chain_d = chain_shift[SYNC_STAGES-1:0];
          if (chain_shift[SYNC_STAGES-1]) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_HOLD;
        cnt_d   = CNT_RELOAD;
        chain_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign rst_n = chain_q[SYNC_STAGES-1];
  assign done  = done_q;

endmodule

// File: rtl/hazard3_reset_ctrl.sv
// Multi-hart reset controller between hazard3_dm and the CPU instances:
// merges system and per-hart DM requests and sequences each hart's reset.
module hazard3_reset_ctrl
  import hazard3_reset_ctrl_pkg::*;
#(
  parameter int N_HARTS     = 1,
  parameter int MIN_PULSE   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sys_reset_req,
  input  logic [N_HARTS-1:0] hart_reset_req,
  output logic               sys_reset_done,
  output logic [N_HARTS-1:0] hart_reset_done,
  output logic [N_HARTS-1:0] rst_n_hart
);

  localparam int W_CNT = cnt_width(MIN_PULSE);

  logic [N_HARTS-1:0] req;

  assign req = hart_reset_req | {N_HARTS{sys_reset_req}};

  for (genvar i = 0; i < N_HARTS; i++) begin : g_hart
    hazard3_reset_ctrl_hart #(
      .MIN_PULSE   (MIN_PULSE),
      .SYNC_STAGES (SYNC_STAGES),
      .W_CNT       (W_CNT)
    ) u_hart (
      .clk   (clk),
      .rst   (rst),
      .req   (req[i]),
      .rst_n (rst_n_hart[i]),
      .done  (hart_reset_done[i])
    );
  end

  assign sys_reset_done = &hart_reset_done;

endmodule

// File: tb/tb_hazard3_reset_ctrl.sv
// Directed bench for hazard3_reset_ctrl: a 4-hart default instance plus a
// minimum-parameter single-hart instance, checked against hand-counted edges.
module tb_hazard3_reset_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       sys_reset_req;
   logic [3:0] hart_reset_req;
   logic       sys_reset_done;
   logic [3:0] hart_reset_done;
   logic [3:0] rst_n_hart;

   logic [0:0] small_hart_req;
   logic       small_sys_done;
   logic [0:0] small_done;
   logic [0:0] small_rst_n;

   int errorCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   hazard3_reset_ctrl #(
      .N_HARTS     (4),
      .MIN_PULSE   (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sys_reset_req   (sys_reset_req),
      .hart_reset_req  (hart_reset_req),
      .sys_reset_done  (sys_reset_done),
      .hart_reset_done (hart_reset_done),
      .rst_n_hart      (rst_n_hart)
   );

   hazard3_reset_ctrl #(
      .N_HARTS     (1),
      .MIN_PULSE   (1),
      .SYNC_STAGES (1)
   ) dut_min (
      .clk             (clk),
      .rst             (rst),
      .sys_reset_req   (1'b0),
      .hart_reset_req  (small_hart_req),
      .sys_reset_done  (small_sys_done),
      .hart_reset_done (small_done),
      .rst_n_hart      (small_rst_n)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic sys, input logic [3:0] hart);
      sys_reset_req  = sys;
      hart_reset_req = hart;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkMain(input string tag, input logic [3:0] rstN, input logic [3:0] done, input logic sysDone);
      checkOutput({tag, "_rst_n"}, 32'(rst_n_hart), 32'(rstN));
      checkOutput({tag, "_done"}, 32'(hart_reset_done), 32'(done));
      checkOutput({tag, "_sys_done"}, 32'(sys_reset_done), 32'(sysDone));
   endtask

   // Harts in lowMask stay in reset for nEdges-1 further edges and release on edge nEdges.
   task automatic runRelease(input string tag, input logic [3:0] lowMask, input int nEdges);
      for (int j = 1; j <= nEdges; j++) begin
         tick(1);
         if (j < nEdges) checkMain($sformatf("%s_e%0d", tag, j), ~lowMask, ~lowMask, 1'b0);
         else            checkMain($sformatf("%s_e%0d", tag, j), 4'hF, 4'hF, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 4'h0);
      small_hart_req = 1'b0;

      #2;
      checkMain("por_async", 4'h0, 4'h0, 1'b0);
      checkOutput("por_async_min", 32'(small_rst_n), 32'd0);
      tick(5);
      checkMain("por_held", 4'h0, 4'h0, 1'b0);
      checkOutput("por_held_min_done", 32'(small_done), 32'd0);

      // Power-on release: main instance rises on edge 18, min instance on edge 2.
      rst = 1'b0;
      for (int j = 1; j <= 18; j++) begin
         tick(1);
         checkMain($sformatf("por_e%0d", j), (j == 18) ? 4'hF : 4'h0, (j == 18) ? 4'hF : 4'h0, j == 18);
         checkOutput($sformatf("por_min_e%0d", j), 32'(small_rst_n), 32'(j >= 2));
      end

      // Single-cycle request to hart 2; no combinational path to outputs.
      applyStimulus(1'b0, 4'b0100);
      #1;
      checkMain("single_comb", 4'hF, 4'hF, 1'b1);
      tick(1);
      applyStimulus(1'b0, 4'h0);
      checkMain("single_e0", 4'b1011, 4'b1011, 1'b0);
      runRelease("single", 4'b0100, 18);

      // System and hart request together behave like a system request.
      applyStimulus(1'b1, 4'b0010);
      tick(1);
      applyStimulus(1'b0, 4'h0);
      checkMain("simul_e0", 4'h0, 4'h0, 1'b0);
      runRelease("simul", 4'hF, 18);

      // System request held for 40 cycles: release on edge k+42.
      applyStimulus(1'b1, 4'h0);
      tick(1);
      checkMain("held_e0", 4'h0, 4'h0, 1'b0);
      tick(39);
      checkMain("held_e39", 4'h0, 4'h0, 1'b0);
      applyStimulus(1'b0, 4'h0);
      runRelease("held", 4'hF, 3);

      // Re-request while hart 0 is in SYNC (edge k+17): release on k+35.
      applyStimulus(1'b0, 4'b0001);
      tick(1);
      applyStimulus(1'b0, 4'h0);
      tick(16);
      checkMain("rereq_e16", 4'b1110, 4'b1110, 1'b0);
      applyStimulus(1'b0, 4'b0001);
      tick(1);
      applyStimulus(1'b0, 4'h0);
      checkMain("rereq_e17", 4'b1110, 4'b1110, 1'b0);
      runRelease("rereq", 4'b0001, 18);

      // rst asserted mid-HOLD (cnt=7) on hart 3, then a full replay.
      applyStimulus(1'b0, 4'b1000);
      tick(1);
      applyStimulus(1'b0, 4'h0);
      tick(8);
      checkMain("midrst_pre", 4'b0111, 4'b0111, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkMain("midrst_async", 4'h0, 4'h0, 1'b0);
      tick(2);
      checkMain("midrst_held", 4'h0, 4'h0, 1'b0);
      rst = 1'b0;
      runRelease("midrst", 4'hF, 18);

      // Minimum parameters: request at edge k, low after k and k+1, high after k+2.
      small_hart_req = 1'b1;
      tick(1);
      small_hart_req = 1'b0;
      checkOutput("min_e0_rst_n", 32'(small_rst_n), 32'd0);
      checkOutput("min_e0_done", 32'(small_done), 32'd0);
      tick(1);
      checkOutput("min_e1_rst_n", 32'(small_rst_n), 32'd0);
      tick(1);
      checkOutput("min_e2_rst_n", 32'(small_rst_n), 32'd1);
      checkOutput("min_e2_done", 32'(small_done), 32'd1);
      checkOutput("min_e2_sys_done", 32'(small_sys_done), 32'd1);
      checkMain("min_main_untouched", 4'hF, 4'hF, 1'b1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
